// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: IM write port, EX redirects, ID handshake and queue status.
// The master drives the requests; if_fetch_queue sits on the slave side.
interface if_fetch_queue_if #(
    parameter int XLEN        = 64,
    parameter int IM_DEPTH    = 512,
    parameter int FETCH_DEPTH = 4
);
    localparam int AW = $clog2(IM_DEPTH);
    localparam int CW = $clog2(FETCH_DEPTH) + 1;

    logic [3:0]      i_wen;
    logic [AW-1:0]   i_waddr;
    logic [31:0]     i_wdata;
    logic            i_id_ready;
    logic            i_branch_in_ex;
    logic [XLEN-1:0] i_branch_target;
    logic            i_jump_in_ex;
    logic [XLEN-1:0] i_jump_target;
    logic [31:0]     o_if_instr;
    logic [XLEN-1:0] o_if_pc;
    logic            o_if_valid_instr;
    logic [CW-1:0]   o_fq_count;

    modport master (
        output i_wen, i_waddr, i_wdata, i_id_ready,
               i_branch_in_ex, i_branch_target, i_jump_in_ex, i_jump_target,
        input  o_if_instr, o_if_pc, o_if_valid_instr, o_fq_count
    );

    modport slave (
        input  i_wen, i_waddr, i_wdata, i_id_ready,
               i_branch_in_ex, i_branch_target, i_jump_in_ex, i_jump_target,
        output o_if_instr, o_if_pc, o_if_valid_instr, o_fq_count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC + sync-read IM feeding a FETCH_DEPTH FIFO to ID; fetch-to-valid is 2 edges.
// ID backpressure via i_id_ready; issue stalls once FIFO + in-flight reaches FETCH_DEPTH.
module if_fetch_queue #(
    parameter int                 XLEN        = 64,
    parameter logic [XLEN-1:0]    RESET_PC    = 'h100,
    parameter int                 IM_DEPTH    = 512,
    parameter int                 FETCH_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_queue_if.slave   bus
);
    localparam int AW = $clog2(IM_DEPTH);
    localparam int PW = $clog2(FETCH_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]     mem [IM_DEPTH];
    logic [31:0]     im_rdata_q;
    logic [31:0]     fq_instr_q [FETCH_DEPTH];
    logic [XLEN-1:0] fq_pc_q    [FETCH_DEPTH];

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fetch_addr;
    logic [AW-1:0]   rd_idx;
    logic            valid;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occ;

    always_comb begin
        redirect   = bus.i_branch_in_ex | bus.i_jump_in_ex;
        target     = (bus.i_branch_in_ex ? bus.i_branch_target : bus.i_jump_target) & ~XLEN'(3);
        fetch_addr = redirect ? target : fetch_pc_q;
        rd_idx     = fetch_addr[AW+1:2];
        valid      = (count_q != '0) & ~redirect;
        pop        = valid & bus.i_id_ready;
        // A redirect kills the in-flight response, so only undisturbed reads land in the FIFO.
        push       = inflight_q & ~redirect;
        occ        = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue      = ~rst & (redirect | (occ < (CW+1)'(FETCH_DEPTH)));

        fetch_pc_d    = issue ? fetch_addr + XLEN'(4) : fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_addr : inflight_pc_q;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // IM and FIFO storage carry no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.i_wen[b]) mem[bus.i_waddr][8*b +: 8] <= bus.i_wdata[8*b +: 8];
        end
        if (issue) im_rdata_q <= mem[rd_idx];
        if (push) begin
            fq_instr_q[wr_ptr_q] <= im_rdata_q;
            fq_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assign bus.o_if_valid_instr = valid;
    assign bus.o_if_instr       = (count_q != '0) ? fq_instr_q[rd_ptr_q] : '0;
    assign bus.o_if_pc          = (count_q != '0) ? fq_pc_q[rd_ptr_q] : '0;
    assign bus.o_fq_count       = count_q;
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage. It holds the fetch PC and owns the instruction memory, which has a 1-cycle synchronous read. Fetched instructions are buffered, with their PCs, in a FETCH_DEPTH-entry FIFO and drained into ID by a valid/ready handshake. Branch/jump redirects from EX flush the FIFO and drop the in-flight read.

Parameters:
XLEN, 64, PC and target width
RESET_PC, 64'h100, PC fetched first after reset
IM_DEPTH, 512, instruction memory depth in 32-bit words (power of 2)
FETCH_DEPTH, 4, fetch FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_wen  in  4  IM byte write enables
i_waddr  in  $clog2(IM_DEPTH)  IM word address for writes
i_wdata  in  32  IM write data
i_id_ready  in  1  ID accepts the head entry this cycle
i_branch_in_ex  in  1  branch taken in EX
i_branch_target  in  XLEN  branch target
i_jump_in_ex  in  1  jump in EX
i_jump_target  in  XLEN  jump target
o_if_instr  out  32  head-entry instruction
o_if_pc  out  XLEN  head-entry PC
o_if_valid_instr  out  1  head entry valid
o_fq_count  out  $clog2(FETCH_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, while rst=1): fetch_pc=RESET_PC, FIFO empty, in-flight flag clear, o_if_valid_instr=0, o_if_instr=0, o_if_pc=0, o_fq_count=0. Reset mid-operation discards all FIFO and in-flight state. IM contents are not reset.
- redirect = i_branch_in_ex | i_jump_in_ex. If both are high, the branch wins. Target bits [1:0] are forced to 0.
- Fetch address = redirect ? target : fetch_pc. The IM read index is fetch address [$clog2(IM_DEPTH)+1:2], which wraps modulo IM_DEPTH.
- Issue condition: rst=0 and (redirect or (fq_count + inflight - pop) < FETCH_DEPTH).
- On issue: the IM read is registered, inflight<=1, inflight_pc<=fetch address, fetch_pc<=fetch address+4 (mod 2^XLEN). Without issue: inflight<=0 and fetch_pc holds.
- Response: at the edge after an issue, IM data plus inflight_pc are pushed into the FIFO, unless a redirect is high at that edge.
- Redirect at an edge: FIFO cleared, in-flight response dropped (not pushed), target issued at the same edge. The first redirected instruction is visible after the next edge (2 edges from the redirect cycle).
- o_if_valid_instr = (fq_count != 0) & ~redirect, combinational. o_if_instr/o_if_pc present the head entry.
- pop = o_if_valid_instr & i_id_ready. Simultaneous push and pop is legal at any occupancy, including full: count is unchanged and order is preserved.
- The issue condition guarantees no push ever hits a full FIFO without a pop. Overflow is impossible; the bench asserts it.
- Pointers wrap modulo FETCH_DEPTH.
- Reset-to-first-valid: fetch of RESET_PC issues at the first edge with rst=0. o_if_valid_instr=1 with o_if_pc=RESET_PC after the second edge.
- Steady state with i_id_ready=1: one instruction per cycle, PCs consecutive +4.
- IM write: at the clock edge, enabled bytes of word i_waddr are written. A same-edge read of the same word returns the old data.
- o_fq_count is registered and reflects the FIFO after the edge.

Test Plan:
1. Preload words 0x40..0x47 (byte 0x100 onward) with 0xA0000000+k, release rst, i_id_ready=1 -> valid after 2nd edge; PCs 0x100,0x104,... with instr 0xA0000000,0xA0000001,... every cycle.
2. Same preload, i_id_ready=0 for 10 cycles -> o_fq_count settles at 4, PCs 0x100..0x10C held in order, no overflow. Then ready=1 -> 4 drained back-to-back, then 0x110 follows with no gap.
3. FIFO holds 3 entries; branch_in_ex=1, target 0x200 for one cycle -> o_if_valid_instr=0 that cycle; FIFO empty after the edge; next valid has pc=0x200; the stale in-flight entry never appears.
4. Branch target 0x300 and jump target 0x400 asserted together -> next valid pc=0x300. Jump alone with target 0x403 -> pc=0x400.
5. Redirect asserted on the same cycle the FIFO is full and ID pops -> FIFO cleared, no push of the old response, count=0 after the edge.
6. Assert rst for one cycle mid-stream while FIFO is non-empty -> outputs 0 immediately; after release, fetch restarts at 0x100 with 2-edge latency.
